rep_code_serial_tx: RTL and testbench

- Repetition-code serial transmitter: the sending end for the 3-input majority voter used as a bit decoder in the MIG datapath.
- Accepts a parallel word over a valid/ready handshake. Shifts it out LSB-first, driving each data bit on the line for REP consecutive cycles (chips).
- A downstream majority voter recovers each bit even if one chip is corrupted.
- Sits between the core's debug/trace word source and the serial link.

---
 rtl/rep_code_serial_tx.sv | 155 +++++++++++++++
 tb/tb_rep_code_serial_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rep_code_serial_tx.sv
// Repetition-code serial transmitter: each data bit is driven for REP chips, LSB first.
// Optional macro REP_CODE_TX_PARITY_EN appends an even-parity bit after the data bits.
module rep_code_serial_tx #(
  parameter int DATA_W = 8,
  parameter int REP    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              tx_frame,
  output logic              busy
);

  localparam int CHIP_W = (REP > 1) ? $clog2(REP) : 1;
`ifdef REP_CODE_TX_PARITY_EN
  localparam int BIT_MAX = DATA_W;
`else
  localparam int BIT_MAX = DATA_W - 1;
`endif
  localparam int BIT_W = (BIT_MAX > 0) ? $clog2(BIT_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   sreg_reg, sreg_next;
  logic [CHIP_W-1:0]   chip_cnt_reg, chip_cnt_next;
  logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic                tx_out_reg, tx_out_next;
  logic                tx_frame_reg, tx_frame_next;
  logic                ready_en_reg;
`ifdef REP_CODE_TX_PARITY_EN
  logic                parity_reg, parity_next;
`endif

  logic last_chip, last_bit, accept;

  assign last_chip = (chip_cnt_reg == CHIP_W'(REP - 1));
  assign last_bit  = (bit_cnt_reg == BIT_W'(DATA_W - 1));

  // ready_en_reg keeps in_ready low until the first edge after reset release
  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      IDLE:   in_ready = ready_en_reg;
`ifdef REP_CODE_TX_PARITY_EN
      PARITY: in_ready = last_chip;
`else
      SEND:   in_ready = last_chip && last_bit;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign tx_out   = tx_out_reg;
  assign tx_frame = tx_frame_reg;
  assign busy     = tx_frame_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sreg_reg     <= '0;
      chip_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_out_reg   <= 1'b0;
      tx_frame_reg <= 1'b0;
      ready_en_reg <= 1'b0;
`ifdef REP_CODE_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      sreg_reg     <= sreg_next;
      chip_cnt_reg <= chip_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      tx_out_reg   <= tx_out_next;
      tx_frame_reg <= tx_frame_next;
      ready_en_reg <= 1'b1;
`ifdef REP_CODE_TX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    sreg_next     = sreg_reg;
    chip_cnt_next = chip_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    tx_out_next   = tx_out_reg;
    tx_frame_next = tx_frame_reg;
`ifdef REP_CODE_TX_PARITY_EN
    parity_next   = parity_reg;
`endif

    case (state_reg)
      SEND: begin
        if (!last_chip) begin
          chip_cnt_next = chip_cnt_reg + 1'b1;
        end else begin
          chip_cnt_next = '0;
          if (!last_bit) begin
            sreg_next    = sreg_reg >> 1;
            tx_out_next  = sreg_next[0];
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end else begin
`ifdef REP_CODE_TX_PARITY_EN
            state_next   = PARITY;
            tx_out_next  = parity_reg;
            bit_cnt_next = bit_cnt_reg + 1'b1;
`else
            state_next    = IDLE;
            tx_out_next   = 1'b0;
            tx_frame_next = 1'b0;
`endif
          end
        end
      end
`ifdef REP_CODE_TX_PARITY_EN
      PARITY: begin
        if (!last_chip) begin
          chip_cnt_next = chip_cnt_reg + 1'b1;
        end else begin
          chip_cnt_next = '0;
          state_next    = IDLE;
          tx_out_next   = 1'b0;
          tx_frame_next = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    // A new word can only be taken in IDLE or on the final chip, so it overrides the frame end
    if (accept) begin
      state_next    = SEND;
      sreg_next     = in_data;
      chip_cnt_next = '0;
      bit_cnt_next  = '0;
      tx_out_next   = in_data[0];
      tx_frame_next = 1'b1;
`ifdef REP_CODE_TX_PARITY_EN
      parity_next   = ^in_data;
`endif
    end
  end

endmodule

// File: tb/tb_rep_code_serial_tx.sv
// Directed bench for rep_code_serial_tx (DATA_W=8, REP=3); parity frames run when
// REP_CODE_TX_PARITY_EN is defined.
module tb_rep_code_serial_tx;

`ifdef REP_CODE_TX_PARITY_EN
  localparam int NCHIPS = 27;
`else
  localparam int NCHIPS = 24;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       tx_out, tx_frame, busy;

  int vectors = 0;
  int miscompares = 0;

  rep_code_serial_tx #(.DATA_W(8), .REP(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx_out(tx_out), .tx_frame(tx_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one frame from its first chip; returns just after the edge following its last chip.
  task automatic run_frame(input logic [7:0] d);
    logic exp_bit;
    for (int i = 0; i < NCHIPS; i++) begin
      exp_bit = (i / 3 < 8) ? d[i / 3] : ^d;
      chk($sformatf("frame%02h_chip%0d_frame", d, i), {31'd0, tx_frame}, 32'd1);
      chk($sformatf("frame%02h_chip%0d_busy", d, i), {31'd0, busy}, 32'd1);
      chk($sformatf("frame%02h_chip%0d_out", d, i), {31'd0, tx_out}, {31'd0, exp_bit});
      chk($sformatf("frame%02h_chip%0d_ready", d, i), {31'd0, in_ready},
          (i == NCHIPS - 1) ? 32'd1 : 32'd0);
      $display("chip %0d of %02h: tx_out=%0b tx_frame=%0b in_ready=%0b", i, d, tx_out, tx_frame, in_ready);
      step();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_frame"}, {31'd0, tx_frame}, 32'd0);
    chk({tag, "_out"}, {31'd0, tx_out}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset held 3 cycles
    step(); step(); step();
    chk("rst_frame", {31'd0, tx_frame}, 32'd0);
    chk("rst_out", {31'd0, tx_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready_before_edge", {31'd0, in_ready}, 32'd0);
    step();
    chk_idle("post_reset");
    step();
    chk_idle("idle");

    // Single word 0xA5
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0; in_data = 8'h00;
    run_frame(8'hA5);
    chk_idle("after_a5");
    $display("single word 0xA5 done");

    // Back-to-back 0x01 then 0xFF with in_valid held
    in_valid = 1'b1; in_data = 8'h01;
    step();
    in_data = 8'hFF;
    run_frame(8'h01);
    in_valid = 1'b0;
    run_frame(8'hFF);
    chk_idle("after_ff");
    $display("back-to-back 0x01/0xFF done");

    // Back-pressure: in_data changes mid-frame
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_data = 8'hC3;
    run_frame(8'h3C);
    in_valid = 1'b0; in_data = 8'h55;
    run_frame(8'hC3);
    chk_idle("after_c3");
    $display("back-pressure 0x3C/0xC3 done");

    // Reset mid-frame at chip 10 of 0xA5, between edges
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("mid_chip10_frame", {31'd0, tx_frame}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_frame", {31'd0, tx_frame}, 32'd0);
    chk("mid_rst_out", {31'd0, tx_out}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    $display("async reset mid-frame: tx_out=%0b tx_frame=%0b", tx_out, tx_frame);
    step();
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      chk_idle($sformatf("post_abort_%0d", i));
    end

    // Single word whose first chip differs from A5's to catch stale state
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    run_frame(8'h5A);
    chk_idle("after_5a");

`ifdef REP_CODE_TX_PARITY_EN
    in_valid = 1'b1; in_data = 8'h07;
    step();
    in_valid = 1'b0;
    run_frame(8'h07);
    chk_idle("after_par07");
    in_valid = 1'b1; in_data = 8'h03;
    step();
    in_valid = 1'b0;
    run_frame(8'h03);
    chk_idle("after_par03");
    $display("parity frames 0x07/0x03 done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
